maze_tile_renderer: RTL

MAZE_TILE_RENDERER -- requirements
Module: maze_tile_renderer

---
 rtl/maze_tile_renderer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer
// Maps each screen pixel onto a tile of a maze bitmap and produces a
// registered colour two cycles after the pixel coordinates arrive.
// Small mazes are centred on a 640x480 screen. Larger ones are shown
// through a scrolling window. All geometry comes from shadow registers
// that are reloaded only at an enabled frame_start, so one frame never
// mixes two configurations.
module maze_tile_renderer #(
    parameter int                 MAX_W        = 100,
    parameter int                 MAX_H        = 100,
    parameter int                 COLOR_W      = 8,
    parameter int                 BLINK_FRAMES = 30,
    parameter logic [COLOR_W-1:0] PATH_COLOR   = 8'hFF,
    parameter logic [COLOR_W-1:0] WALL_COLOR   = 8'h00,
    parameter logic [COLOR_W-1:0] CURSOR_COLOR = 8'hE0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     frame_start,
    input  logic                     video_on,
    input  logic [9:0]               pixel_x,
    input  logic [9:0]               pixel_y,
    input  logic [MAX_W*MAX_H-1:0]   path_data,
    input  logic [6:0]               maze_width,
    input  logic [6:0]               maze_height,
    input  logic [2:0]               tile_shift,
    input  logic [6:0]               view_x,
    input  logic [6:0]               view_y,
    input  logic [6:0]               cursor_x,
    input  logic [6:0]               cursor_y,
    output logic [COLOR_W-1:0]       rgb,
    output logic                     scroll_mode
);

    localparam int NPIX  = MAX_W * MAX_H;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [6:0]       sh_w, sh_h, sh_cx, sh_cy;
    logic [2:0]       sh_shift;
    logic [10:0]      sh_vx, sh_vy;

    logic [10:0]      cap_vw, cap_vh, cap_mw, cap_mh, cap_lx, cap_ly, cap_vx, cap_vy;

    logic [CNT_W-1:0] frame_cnt;
    logic             blink_on;

    logic [13:0]      pw, ph, ox, oy, px, py, dx, dy, tx_c, ty_c;
    logic [10:0]      tx_s, ty_s;
    logic             centred, legal, in_c, in_s, cur_ok;
    logic [13:0]      s1_tx_n, s1_ty_n;
    logic             s1_in_n, s1_cur_n;

    logic [13:0]      s1_tx, s1_ty;
    logic             s1_vid, s1_in, s1_cur;

    logic [31:0]      idx;
    logic             in_range, path_bit;
    logic [IDX_W-1:0] rd_idx;
    logic [COLOR_W-1:0] rgb_n;

    // View clamp is resolved from the live inputs so the shadow holds a final window origin
    always_comb begin
        cap_vw = 11'd640 >> tile_shift;
        cap_vh = 11'd480 >> tile_shift;
        cap_mw = {4'd0, maze_width};
        cap_mh = {4'd0, maze_height};
        cap_lx = cap_mw - cap_vw;
        cap_ly = cap_mh - cap_vh;
        cap_vx = '0;
        cap_vy = '0;
        if (cap_mw > cap_vw) begin
            cap_vx = ({4'd0, view_x} < cap_lx) ? {4'd0, view_x} : cap_lx;
        end
        if (cap_mh > cap_vh) begin
            cap_vy = ({4'd0, view_y} < cap_ly) ? {4'd0, view_y} : cap_ly;
        end
    end

    // Shadow configuration: zero width/height after reset keeps the screen black
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_w     <= '0;
            sh_h     <= '0;
            sh_shift <= '0;
            sh_vx    <= '0;
            sh_vy    <= '0;
            sh_cx    <= '0;
            sh_cy    <= '0;
        end else if (frame_start && enable) begin
            sh_w     <= maze_width;
            sh_h     <= maze_height;
            sh_shift <= tile_shift;
            sh_vx    <= cap_vx;
            sh_vy    <= cap_vy;
            sh_cx    <= cursor_x;
            sh_cy    <= cursor_y;
        end
    end

    // Cursor blink: frame counter runs on every frame_start regardless of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1 mapping: pixel to tile coordinate and inside flag for the current mode
    always_comb begin
        pw      = {7'd0, sh_w} << sh_shift;
        ph      = {7'd0, sh_h} << sh_shift;
        centred = (pw <= 14'd640) && (ph <= 14'd480);
        ox      = (14'd640 - pw) >> 1;
        oy      = (14'd480 - ph) >> 1;
        px      = {4'd0, pixel_x};
        py      = {4'd0, pixel_y};
        dx      = px - ox;
        dy      = py - oy;
        tx_c    = dx >> sh_shift;
        ty_c    = dy >> sh_shift;
        in_c    = (px >= ox) && (px < ox + pw) && (py >= oy) && (py < oy + ph);
        tx_s    = sh_vx + {1'b0, pixel_x >> sh_shift};
        ty_s    = sh_vy + {1'b0, pixel_y >> sh_shift};
        in_s    = (tx_s < {4'd0, sh_w}) && (ty_s < {4'd0, sh_h});
        legal   = (sh_w != 7'd0) && (sh_h != 7'd0);
        if (centred) begin
            s1_tx_n = tx_c;
            s1_ty_n = ty_c;
            s1_in_n = legal && in_c;
        end else begin
            s1_tx_n = {3'd0, tx_s};
            s1_ty_n = {3'd0, ty_s};
            s1_in_n = legal && in_s;
        end
        // Cursor match is taken with the same shadow snapshot as the tile it is compared to
        cur_ok   = (sh_cx < sh_w) && (sh_cy < sh_h);
        s1_cur_n = cur_ok && (s1_tx_n == {7'd0, sh_cx}) && (s1_ty_n == {7'd0, sh_cy});
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_tx  <= '0;
            s1_ty  <= '0;
            s1_in  <= 1'b0;
            s1_cur <= 1'b0;
            s1_vid <= 1'b0;
        end else begin
            s1_tx  <= s1_tx_n;
            s1_ty  <= s1_ty_n;
            s1_in  <= s1_in_n;
            s1_cur <= s1_cur_n;
            s1_vid <= video_on;
        end
    end

    // Mode flag follows the shadow one cycle after capture
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_mode <= 1'b0;
        end else begin
            scroll_mode <= ~centred;
        end
    end

    // Stage 2 colour select; out-of-range indices are steered to bit 0 and masked
    always_comb begin
        idx      = ({18'd0, s1_ty} * 32'(MAX_W)) + {18'd0, s1_tx};
        in_range = idx < 32'(NPIX);
        rd_idx   = in_range ? idx[IDX_W-1:0] : '0;
        path_bit = in_range && path_data[rd_idx];
        rgb_n    = WALL_COLOR;
        if (!s1_vid || !s1_in) begin
            rgb_n = '0;
        end else if (s1_cur && blink_on) begin
            rgb_n = CURSOR_COLOR;
        end else if (path_bit) begin
            rgb_n = PATH_COLOR;
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_n;
        end
    end

endmodule
